ppu_line_doubler: RTL

- Ping-pong scanline buffer between the PPU pixel path (palette-index stream) and the VGA controller.
- Accepts one 256-pixel NES scanline at a time and stores it in a free bank.
- Replays each stored line on two consecutive VGA lines with 2x horizontal pixel replication, producing a centred 512x480 image with side borders inside the 640x480 active area.
- Issues line requests upstream so the renderer produces the next line only when a bank is free.

---
 rtl/ppu_line_doubler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ppu_line_doubler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppu_line_doubler: ping-pong NES scanline buffer, 2x line/pixel replay to VGA
// Revision: 1.0
// ---------------------------------------------------------------------------
module ppu_line_doubler #(
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter int         LINE_PIX   = 256,
  parameter int         H_OFFSET   = 64,
  parameter logic [5:0] BORDER_IDX = 6'h0F
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [5:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       line_req,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       blank_n,
  output logic [5:0] pix_out,
  output logic       pix_valid,
  output logic       underrun,
  output logic       overflow,
  input  logic       err_clr
);

  localparam int AW = $clog2(LINE_PIX);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  localparam logic [9:0]    c_h_last   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    c_v_lim    = 10'(V_ACTIVE);
  localparam logic [9:0]    c_h_first  = 10'(H_OFFSET);
  localparam logic [9:0]    c_h_end    = 10'(H_OFFSET + 2 * LINE_PIX);
  localparam logic [AW-1:0] c_cnt_last = AW'(LINE_PIX - 1);

  logic [0:0]    wr_state_q, wr_state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          underrun_q, underrun_d;
  logic          overflow_q, overflow_d;
  logic          pix_valid_q, pix_valid_d;
  logic          in_line_q, in_line_d;
  logic [5:0]    rd_data_q;

  logic          wr_en;
  logic          last_wr;
  logic          swap;
  logic [9:0]    col;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   rd_addr;

  logic [5:0] mem [0:2*LINE_PIX-1];

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;

    wr_en   = (wr_state_q == FILL) && wr_valid;
    last_wr = wr_en && (wr_cnt_q == c_cnt_last);
    swap    = blank_n && (hcount == c_h_last) && vcount[0] && (vcount < c_v_lim);

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (last_wr) begin
        wr_state_d = FULL;
        wr_cnt_d   = '0;
      end
    end

    // A line finishing on the swap cycle still counts as complete.
    if (swap) begin
      if ((wr_state_q == FULL) || last_wr) begin
        wr_bank_d  = ~wr_bank_q;
        wr_state_d = FILL;
        wr_cnt_d   = '0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (wr_valid && (wr_state_q == FULL)) overflow_d = 1'b1;

    if (err_clr) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end

    col         = hcount - c_h_first;
    rd_idx      = AW'(col >> 1);
    rd_addr     = {~wr_bank_q, rd_idx};
    in_line_d   = (hcount >= c_h_first) && (hcount < c_h_end);
    pix_valid_d = blank_n;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      wr_state_q  <= FILL;
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      in_line_q   <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      pix_valid_q <= pix_valid_d;
      in_line_q   <= in_line_d;
    end
  end

  // Write and read always target opposite banks, so no collision handling.
  always_ff @(posedge VGA_CLK) begin
    if (wr_en) mem[{wr_bank_q, wr_cnt_q}] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign wr_ready  = (wr_state_q == FILL);
  assign line_req  = (wr_state_q == FILL) && (wr_cnt_q == '0);
  assign pix_valid = pix_valid_q;
  assign pix_out   = !pix_valid_q ? 6'h00 : (in_line_q ? rd_data_q : BORDER_IDX);
  assign underrun  = underrun_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
